// File: rtl/fetch_stage.sv
// Fetch stage: registered PC, next-PC selection and IF/ID pipeline register.
// Handles memory wait states, hazard stall, flush, misaligned redirects and a fetch counter.
module fetch_stage #(
   parameter int unsigned           WIDTH        = 32,
   parameter logic [WIDTH-1:0]      RESET_VECTOR = '0,
   parameter int unsigned           CNT_W        = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic [WIDTH-1:0] imem_addr,
   output logic             imem_req,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   input  logic             stall,
   input  logic             flush,
   input  logic             pc_src,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [25:0]      jump_index,
   output logic [WIDTH-1:0] pc,
   output logic             id_valid,
   output logic [31:0]      id_instr,
   output logic [WIDTH-1:0] id_pc_plus4,
   output logic             fetch_misalign,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [0:0] {StBoot, StFetch} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  pc_q, pc_d;
   logic              id_valid_q, id_valid_d;
   logic [31:0]       id_instr_q, id_instr_d;
   logic [WIDTH-1:0]  id_pc_plus4_q, id_pc_plus4_d;
   logic              misalign_q, misalign_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [WIDTH-1:0]  pc_plus4;
   logic [WIDTH-1:0]  branch_pc;
   logic [WIDTH-1:0]  jump_pc;

   assign pc_plus4  = pc_q + WIDTH'(4);
   assign branch_pc = {branch_target[WIDTH-1:2], 2'b00};

   // Jump keeps the upper region bits of the delay-slot PC; none exist at the minimum width.
   if (WIDTH > 28) begin : g_jump_region
      assign jump_pc = {id_pc_plus4_q[WIDTH-1:28], jump_index, 2'b00};
   end else begin : g_jump_flat
      assign jump_pc = {jump_index, 2'b00};
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      id_valid_d    = id_valid_q;
      id_instr_d    = id_instr_q;
      id_pc_plus4_d = id_pc_plus4_q;
      misalign_d    = misalign_q;
      count_d       = count_q;
      imem_req      = 1'b0;

      unique case (state_q)
         StBoot: begin
            state_d = StFetch;
         end
         StFetch: begin
            imem_req = ~stall;
            if (pc_src || jump) begin
               pc_d       = pc_src ? branch_pc : jump_pc;
               id_valid_d = 1'b0;
               if (pc_src && (branch_target[1:0] != 2'b00)) begin
                  misalign_d = 1'b1;
               end
            end else if (stall) begin
               // Hold everything; the same pc is refetched once the stall lifts.
            end else if (flush) begin
               id_valid_d = 1'b0;
               if (imem_ready) begin
                  pc_d = pc_plus4;
               end
            end else if (imem_ready) begin
               pc_d          = pc_plus4;
               id_valid_d    = 1'b1;
               id_instr_d    = imem_rdata;
               id_pc_plus4_d = pc_plus4;
               count_d       = count_q + CNT_W'(1);
            end else begin
               id_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StBoot;
         pc_q          <= RESET_VECTOR;
         id_valid_q    <= 1'b0;
         id_instr_q    <= '0;
         id_pc_plus4_q <= '0;
         misalign_q    <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         id_valid_q    <= id_valid_d;
         id_instr_q    <= id_instr_d;
         id_pc_plus4_q <= id_pc_plus4_d;
         misalign_q    <= misalign_d;
         count_q       <= count_d;
      end
   end

   assign pc             = pc_q;
   assign imem_addr      = pc_q;
   assign id_valid       = id_valid_q;
   assign id_instr       = id_instr_q;
   assign id_pc_plus4    = id_pc_plus4_q;
   assign fetch_misalign = misalign_q;
   assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, wait states, redirects, stall/flush,
// misalignment and PC wrap.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        flush;
   logic        pc_src;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;
   logic        fetch_misalign;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_req       (imem_req),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .stall          (stall),
      .flush          (flush),
      .pc_src         (pc_src),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_index     (jump_index),
      .pc             (pc),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc_plus4    (id_pc_plus4),
      .fetch_misalign (fetch_misalign),
      .fetch_count    (fetch_count)
   );

   always #5 clock = ~clock;

   // Combinational instruction memory: word tagged with its own address.
   assign imem_rdata = 32'hA000_0000 | imem_addr;

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic idle_inputs();
      imem_ready = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
      branch_target = '0; jump = 1'b0; jump_index = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      #3;
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", fetch_misalign); end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", imem_req); end
      tick();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL fetch_req got=%b exp=1", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL fetch_addr got=%h exp=0", imem_addr); end
   endtask

   task automatic test_stream();
      imem_ready = 1'b1;
      tick();
      total++; if (pc !== 32'h4) begin bad++; $display("FAIL stream_pc0 got=%h exp=4", pc); end
      total++; if (id_valid !== 1'b1 || id_instr !== 32'hA000_0000)
         begin bad++; $display("FAIL stream_instr0 got=%b/%h exp=1/a0000000", id_valid, id_instr); end
      total++; if (id_pc_plus4 !== 32'h4 || fetch_count !== 32'd1)
         begin bad++; $display("FAIL stream_pp4_cnt0 got=%h/%0d exp=4/1", id_pc_plus4, fetch_count); end
      tick();
      total++; if (pc !== 32'h8 || id_instr !== 32'hA000_0004)
         begin bad++; $display("FAIL stream_1 got=%h/%h exp=8/a0000004", pc, id_instr); end
      total++; if (id_pc_plus4 !== 32'h8 || fetch_count !== 32'd2)
         begin bad++; $display("FAIL stream_pp4_cnt1 got=%h/%0d exp=8/2", id_pc_plus4, fetch_count); end
   endtask

   task automatic test_wait_states();
      imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (pc !== 32'h8 || id_valid !== 1'b0)
            begin bad++; $display("FAIL wait_%0d got=%h/%b exp=8/0", i, pc, id_valid); end
      end
      imem_ready = 1'b1;
      tick();
      total++; if (id_instr !== 32'hA000_0008 || pc !== 32'hC || id_valid !== 1'b1)
         begin bad++; $display("FAIL wait_done got=%h/%h/%b exp=a0000008/c/1", id_instr, pc, id_valid); end
      total++; if (fetch_count !== 32'd3 || id_pc_plus4 !== 32'hC)
         begin bad++; $display("FAIL wait_cnt got=%0d/%h exp=3/c", fetch_count, id_pc_plus4); end
   endtask

   task automatic test_branch_jump();
      tick();
      total++; if (pc !== 32'h10 || fetch_count !== 32'd4)
         begin bad++; $display("FAIL bj_setup got=%h/%0d exp=10/4", pc, fetch_count); end
      pc_src = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_index = 26'h3FF_FFFF;
      tick();
      total++; if (pc !== 32'h40 || id_valid !== 1'b0 || fetch_count !== 32'd4)
         begin bad++; $display("FAIL branch_prio got=%h/%b/%0d exp=40/0/4", pc, id_valid, fetch_count); end
      jump = 1'b0; branch_target = 32'h1000_0004;
      tick();
      pc_src = 1'b0;
      tick();
      total++; if (id_pc_plus4 !== 32'h1000_0008 || fetch_count !== 32'd5)
         begin bad++; $display("FAIL jump_setup got=%h/%0d exp=10000008/5", id_pc_plus4, fetch_count); end
      jump = 1'b1; jump_index = 26'h10;
      tick();
      jump = 1'b0;
      total++; if (pc !== 32'h1000_0040 || id_valid !== 1'b0 || fetch_count !== 32'd5)
         begin bad++; $display("FAIL jump_pc got=%h/%b/%0d exp=10000040/0/5", pc, id_valid, fetch_count); end
   endtask

   task automatic test_stall_flush();
      pc_src = 1'b1; branch_target = 32'h10;
      tick();
      pc_src = 1'b0;
      tick();
      total++; if (pc !== 32'h14 || id_instr !== 32'hA000_0010 || fetch_count !== 32'd6)
         begin bad++; $display("FAIL stall_setup got=%h/%h/%0d exp=14/a0000010/6", pc, id_instr, fetch_count); end
      stall = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", imem_req); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (pc !== 32'h14 || id_valid !== 1'b1 || id_instr !== 32'hA000_0010 ||
                      id_pc_plus4 !== 32'h14 || fetch_count !== 32'd6)
            begin bad++; $display("FAIL stall_hold_%0d got=%h/%b/%h/%h/%0d exp=14/1/a0000010/14/6",
                                  i, pc, id_valid, id_instr, id_pc_plus4, fetch_count); end
      end
      pc_src = 1'b1; branch_target = 32'h80;
      tick();
      total++; if (pc !== 32'h80 || id_valid !== 1'b0)
         begin bad++; $display("FAIL stall_redirect got=%h/%b exp=80/0", pc, id_valid); end
      stall = 1'b0; pc_src = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (pc !== 32'h84 || id_valid !== 1'b0 || fetch_count !== 32'd6)
         begin bad++; $display("FAIL flush got=%h/%b/%0d exp=84/0/6", pc, id_valid, fetch_count); end
   endtask

   task automatic test_misalign_wrap();
      total++; if (fetch_misalign !== 1'b0)
         begin bad++; $display("FAIL misalign_pre got=%b exp=0", fetch_misalign); end
      pc_src = 1'b1; branch_target = 32'h42;
      tick();
      total++; if (pc !== 32'h40 || fetch_misalign !== 1'b1)
         begin bad++; $display("FAIL misalign_set got=%h/%b exp=40/1", pc, fetch_misalign); end
      branch_target = 32'h100;
      tick();
      total++; if (pc !== 32'h100 || fetch_misalign !== 1'b1)
         begin bad++; $display("FAIL misalign_sticky got=%h/%b exp=100/1", pc, fetch_misalign); end
      branch_target = 32'hFFFF_FFFC;
      tick();
      pc_src = 1'b0;
      tick();
      total++; if (pc !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instr !== 32'hFFFF_FFFC)
         begin bad++; $display("FAIL wrap got=%h/%h/%h exp=0/0/fffffffc", pc, id_pc_plus4, id_instr); end
      total++; if (fetch_count !== 32'd7 || fetch_misalign !== 1'b1)
         begin bad++; $display("FAIL wrap_cnt got=%0d/%b exp=7/1", fetch_count, fetch_misalign); end
   endtask

   task automatic test_reset_mid_wait();
      pc_src = 1'b1; branch_target = 32'h20;
      tick();
      pc_src = 1'b0; imem_ready = 1'b0;
      tick();
      total++; if (pc !== 32'h20) begin bad++; $display("FAIL midwait_setup got=%h exp=20", pc); end
      #1;
      reset_n = 1'b0;
      #1;
      total++; if (pc !== 32'h0 || id_valid !== 1'b0 || fetch_count !== 32'd0 || fetch_misalign !== 1'b0)
         begin bad++; $display("FAIL midwait_reset got=%h/%b/%0d/%b exp=0/0/0/0",
                               pc, id_valid, fetch_count, fetch_misalign); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midwait_req got=%b exp=0", imem_req); end
      @(negedge clock);
      reset_n = 1'b1;
      imem_ready = 1'b1; pc_src = 1'b1; branch_target = 32'h80;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reboot_req got=%b exp=0", imem_req); end
      tick();
      total++; if (pc !== 32'h0 || id_valid !== 1'b0 || imem_req !== 1'b1 || fetch_count !== 32'd0)
         begin bad++; $display("FAIL boot_ignore got=%h/%b/%b/%0d exp=0/0/1/0",
                               pc, id_valid, imem_req, fetch_count); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait_states();
      test_branch_jump();
      test_stall_flush();
      test_misalign_wrap();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
